pwm_meas: RTL



---
 rtl/pwm_meas_pkg.sv | 14 +
 rtl/pwm_meas_div.sv | 60 ++++++
 rtl/pwm_meas.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pwm_meas_pkg.sv
// pwm_meas_pkg: shared constants, FSM encoding and divider latency for pwm_meas
package pwm_meas_pkg;
  localparam int DEF_DUTY_W = 7;
  localparam int PCT = 100;
  localparam int PCT_W = 7;
  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEAS,
    STUCK
  } state_e;
  function automatic int div_lat(input int cnt_w);
    return cnt_w + PCT_W;
  endfunction
endpackage

// File: rtl/pwm_meas_div.sv
// pwm_meas_div: unsigned restoring divider, one quotient bit per cycle, low QW quotient bits kept
module pwm_meas_div #(
  parameter int NW = 33,
  parameter int DW = 26,
  parameter int QW = NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quot
);
  localparam int CW = $clog2(NW + 1);
  logic [NW-1:0] num_q, num_d, num_s;
  logic [DW-1:0] den_q, den_d, rem_q, rem_d, rem_s;
  logic [QW-1:0] quot_q, quot_d, quot_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   trial;
  logic          done_q, done_d, go, step, ge;
  assign busy = cnt_q != '0;
  assign done = done_q;
  assign quot = quot_q;
  assign go   = start & ~busy;
  assign step = go | busy;
  // the start cycle already performs the first iteration, so NW edges finish the quotient
  always_comb begin
    num_s  = go ? num : num_q;
    den_d  = go ? den : den_q;
    rem_s  = go ? '0 : rem_q;
    quot_s = go ? '0 : quot_q;
    trial  = {rem_s, num_s[NW-1]};
    ge     = trial >= {1'b0, den_d};
    num_d  = step ? num_s << 1 : num_q;
    rem_d  = !step ? rem_q : ge ? DW'(trial - {1'b0, den_d}) : DW'(trial);
    quot_d = step ? QW'({quot_s, ge}) : quot_q;
    cnt_d  = go ? CW'(NW - 1) : busy ? cnt_q - 1'b1 : cnt_q;
    done_d = busy && cnt_q == CW'(1);
  end
  // iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/pwm_meas.sv
// pwm_meas: measures period, high time and duty percent of an asynchronous PWM input
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(50_000_000),
  parameter int               DUTY_W  = DEF_DUTY_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              ovr
);
  localparam int NW = div_lat(CNT_W);
  state_e state_q, state_d;
  logic s1_q, s2_q, prev_q, rise;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, p_q, p_d, h_q, h_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d, quot;
  logic valid_q, valid_d, stuck_q, stuck_d, ovr_q, ovr_d;
  logic div_start, div_busy, div_done;
  assign rise      = s2_q & ~prev_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign ovr       = ovr_q;
  pwm_meas_div #(
    .NW(NW),
    .DW(CNT_W),
    .QW(DUTY_W)
  ) u_div (
    .clk  (sys_clk),
    .rst  (rst),
    .start(div_start),
    .num  (NW'(hi_q) * NW'(PCT)),
    .den  (per_q),
    .busy (div_busy),
    .done (div_done),
    .quot (quot)
  );
  // next state: rise beats timeout, timeout beats a finishing divide
  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    p_d       = p_q;
    h_d       = h_q;
    period_d  = period_q;
    high_d    = high_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    ovr_d     = 1'b0;
    stuck_d   = stuck_q;
    div_start = 1'b0;
    if (state_q == MEAS) begin
      per_d = &per_q ? per_q : per_q + 1'b1;
      hi_d  = (s2_q && !(&hi_q)) ? hi_q + 1'b1 : hi_q;
    end
    if (div_done) begin
      period_d = p_q;
      high_d   = h_q;
      duty_d   = quot;
      valid_d  = 1'b1;
    end
    if (rise) begin
      per_d   = CNT_W'(1);
      hi_d    = CNT_W'(1);
      state_d = MEAS;
      stuck_d = 1'b0;
      if (state_q == MEAS) begin
        ovr_d     = div_busy;
        div_start = !div_busy;
        p_d       = div_busy ? p_q : per_q;
        h_d       = div_busy ? h_q : hi_q;
      end
    end else if (state_q == MEAS && per_q == TIMEOUT) begin
      state_d  = STUCK;
      period_d = '0;
      high_d   = '0;
      duty_d   = s2_q ? DUTY_W'(PCT) : '0;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
    end
  end
  // synchronizer, FSM, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= WAIT_FIRST;
      per_q    <= '0;
      hi_q     <= '0;
      p_q      <= '0;
      h_q      <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      p_q      <= p_d;
      h_q      <= h_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule
